// File: rtl/rl_pkg.sv
// rl_pkg: shared action width, Q-value width default and LFSR constants
package rl_pkg;
  localparam int ACT_W = 2;
  localparam int NUM_ACT = 4;
  localparam int QW_DEF = 32;
  // taps b15, b13, b12, b10 -> x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_INIT_VAL = 16'hACE1;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR with seed load (zero seed replaced by INIT)
//   clk, rst : clock, async active-high reset (value <= INIT)
//   adv      : advance one step
//   load     : load seed; wins over adv
//   seed     : seed value
//   value    : current LFSR state
module lfsr16 import rl_pkg::*; #(
  parameter logic [15:0] INIT = LFSR_INIT_VAL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] value
);
  always_ff @(posedge clk or posedge rst)
    if (rst) value <= INIT;
    else if (load) value <= (seed == '0) ? INIT : seed;
    else if (adv) value <= lfsr_next(value);
endmodule

// File: rtl/action_selector.sv
// action_selector: 2-stage max/min search over a 4-entry Q row plus epsilon-greedy action pick
//   clk, rst            : clock, async active-high reset
//   in_valid, Q0..Q3    : input row (signed Q-values)
//   epsilon             : exploration threshold (unsigned)
//   seed_load, seed     : LFSR reseed
//   out_valid           : results valid (latency 2)
//   Amax, Amin, Qmax    : greedy action, worst action, row maximum
//   A, explore          : chosen action, 1 when A came from the random draw
module action_selector import rl_pkg::*; #(
  parameter int QW = QW_DEF,
  parameter int EPS_W = 16,
  parameter logic [15:0] LFSR_INIT = LFSR_INIT_VAL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [QW-1:0]    Q0,
  input  logic signed [QW-1:0]    Q1,
  input  logic signed [QW-1:0]    Q2,
  input  logic signed [QW-1:0]    Q3,
  input  logic [EPS_W-1:0]        epsilon,
  input  logic                    seed_load,
  input  logic [15:0]             seed,
  output logic                    out_valid,
  output logic [ACT_W-1:0]        Amax,
  output logic [ACT_W-1:0]        Amin,
  output logic signed [QW-1:0]    Qmax,
  output logic [ACT_W-1:0]        A,
  output logic                    explore
);
  localparam int CW = (EPS_W > 16) ? EPS_W : 16;
  logic [15:0] lfsr_v;
  logic v1;
  logic signed [QW-1:0] mx01, mx23, mn01, mn23;
  logic ix01, ix23, in01, in23;
  logic [15:0] rnd_q;
  logic [EPS_W-1:0] eps_q;
  logic hi_max, hi_min, explore_n;
  logic [ACT_W-1:0] amax_n, amin_n;
  logic signed [QW-1:0] qmax_n;

  // the row samples the pre-advance value; the LFSR steps on the same edge
  lfsr16 #(.INIT(LFSR_INIT)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .adv  (in_valid),
    .load (seed_load),
    .seed (seed),
    .value(lfsr_v)
  );

  // strict compares keep the lower index on ties
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1 <= 1'b0;
      mx01 <= '0;
      mx23 <= '0;
      mn01 <= '0;
      mn23 <= '0;
      ix01 <= 1'b0;
      ix23 <= 1'b0;
      in01 <= 1'b0;
      in23 <= 1'b0;
      rnd_q <= '0;
      eps_q <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        ix01 <= Q1 > Q0;
        mx01 <= (Q1 > Q0) ? Q1 : Q0;
        ix23 <= Q3 > Q2;
        mx23 <= (Q3 > Q2) ? Q3 : Q2;
        in01 <= Q1 < Q0;
        mn01 <= (Q1 < Q0) ? Q1 : Q0;
        in23 <= Q3 < Q2;
        mn23 <= (Q3 < Q2) ? Q3 : Q2;
        rnd_q <= lfsr_v;
        eps_q <= epsilon;
      end
    end

  always_comb begin
    hi_max = mx23 > mx01;
    hi_min = mn23 < mn01;
    amax_n = hi_max ? {1'b1, ix23} : {1'b0, ix01};
    amin_n = hi_min ? {1'b1, in23} : {1'b0, in01};
    qmax_n = hi_max ? mx23 : mx01;
    explore_n = CW'(rnd_q) < CW'(eps_q);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      Amax <= '0;
      Amin <= '0;
      Qmax <= '0;
      A <= '0;
      explore <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        Amax <= amax_n;
        Amin <= amin_n;
        Qmax <= qmax_n;
        explore <= explore_n;
        A <= explore_n ? rnd_q[ACT_W-1:0] : amax_n;
      end
    end
endmodule

// File: tb/tb_action_selector.sv
// tb_action_selector: directed self-checking bench for action_selector
module tb_action_selector;
  typedef struct {
    logic [1:0]  amax;
    logic [1:0]  amin;
    logic [31:0] qmax;
    logic [1:0]  a;
    logic        ex;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [31:0] q0 = '0, q1 = '0, q2 = '0, q3 = '0;
  logic [15:0] epsilon = '0;
  logic seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic out_valid;
  logic [1:0] amax, amin, a;
  logic signed [31:0] qmax;
  logic explore;

  int checks = 0;
  int errors = 0;
  logic armed = 1'b0;
  logic [15:0] lfsr_m = 16'hACE1;
  logic [1:0] vh;
  exp_t eq[$];
  exp_t got_e;

  always #5 clk = ~clk;

  action_selector dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .Q0       (q0),
    .Q1       (q1),
    .Q2       (q2),
    .Q3       (q3),
    .epsilon  (epsilon),
    .seed_load(seed_load),
    .seed     (seed),
    .out_valid(out_valid),
    .Amax     (amax),
    .Amin     (amin),
    .Qmax     (qmax),
    .A        (a),
    .explore  (explore)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic exp_t model(input logic signed [31:0] x0, x1, x2, x3,
                                 input logic [15:0] rnd, input logic [15:0] eps);
    logic signed [31:0] q[4];
    logic signed [31:0] mx, mn;
    exp_t e;
    q = '{x0, x1, x2, x3};
    mx = x0;
    mn = x0;
    e.amax = 0;
    e.amin = 0;
    for (int i = 1; i < 4; i++) begin
      if (q[i] > mx) begin mx = q[i]; e.amax = 2'(i); end
      if (q[i] < mn) begin mn = q[i]; e.amin = 2'(i); end
    end
    e.qmax = mx;
    e.ex = rnd < eps;
    e.a = e.ex ? rnd[1:0] : e.amax;
    return e;
  endfunction

  task automatic send(input logic signed [31:0] x0, x1, x2, x3, input logic [15:0] eps,
                      input logic ld, input logic [15:0] sd);
    q0 = x0; q1 = x1; q2 = x2; q3 = x3;
    epsilon = eps;
    seed_load = ld;
    seed = sd;
    in_valid = 1'b1;
    eq.push_back(model(x0, x1, x2, x3, lfsr_m, eps));
    @(posedge clk);
    lfsr_m = ld ? ((sd == 16'h0) ? 16'hACE1 : sd) : step(lfsr_m);
    #1;
    in_valid = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic load_seed(input logic [15:0] sd);
    seed_load = 1'b1;
    seed = sd;
    in_valid = 1'b0;
    @(posedge clk);
    lfsr_m = (sd == 16'h0) ? 16'hACE1 : sd;
    #1;
    seed_load = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_rand(input logic [15:0] eps);
    send(32'(int'($urandom_range(0, 6)) - 3), 32'($urandom), 32'(int'($urandom_range(0, 6)) - 3),
         32'($urandom), eps, 1'b0, 16'h0);
  endtask

  // independent valid history: out_valid must echo in_valid two edges later
  always @(posedge clk or posedge rst)
    if (rst) vh <= '0;
    else vh <= {vh[0], in_valid};

  always @(negedge clk)
    if (armed && !rst) begin
      check("out_valid_seq", out_valid, vh[1]);
      if (out_valid) begin
        check("queue_nonempty", eq.size() != 0, 1);
        if (eq.size() != 0) begin
          got_e = eq.pop_front();
          check("m_amax", amax, got_e.amax);
          check("m_amin", amin, got_e.amin);
          check("m_qmax", qmax, got_e.qmax);
          check("m_a", a, got_e.a);
          check("m_explore", explore, got_e.ex);
        end
      end
    end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_amax", amax, 0);
    check("rst_amin", amin, 0);
    check("rst_qmax", qmax, 0);
    check("rst_a", a, 0);
    check("rst_explore", explore, 0);
    rst = 1'b0;
    armed = 1'b1;
    idle(2);

    send(5, -3, 12, 12, 16'h0, 1'b0, 16'h0);
    @(posedge clk); @(negedge clk);
    check("t1_valid", out_valid, 1);
    check("t1_amax", amax, 2);
    check("t1_amin", amin, 1);
    check("t1_qmax", qmax, 12);
    check("t1_a", a, 2);
    check("t1_explore", explore, 0);
    @(negedge clk);
    check("t1_once", out_valid, 0);
    check("t1_hold_amax", amax, 2);
    check("t1_hold_qmax", qmax, 12);

    send(32'h80000000, 32'h7FFFFFFF, 0, -1, 16'h0, 1'b0, 16'h0);
    @(posedge clk); @(negedge clk);
    check("sb_amax", amax, 1);
    check("sb_amin", amin, 0);
    check("sb_qmax", qmax, 32'h7FFFFFFF);

    load_seed(16'h0003);
    send(10, 1, 2, 3, 16'hFFFF, 1'b0, 16'h0);
    send(10, 1, 2, 3, 16'hFFFF, 1'b0, 16'h0);
    @(negedge clk);
    check("fx1_amax", amax, 0);
    check("fx1_explore", explore, 1);
    check("fx1_a", a, 3);
    @(posedge clk); @(negedge clk);
    check("fx2_explore", explore, 1);
    check("fx2_a", a, 2);

    load_seed(16'h0000);
    send(1, 2, 3, 4, 16'hACE2, 1'b0, 16'h0);
    @(posedge clk); @(negedge clk);
    check("zs_explore_above", explore, 1);
    check("zs_a", a, 1);
    load_seed(16'h0000);
    send(1, 2, 3, 4, 16'hACE1, 1'b0, 16'h0);
    @(posedge clk); @(negedge clk);
    check("zs_explore_equal", explore, 0);
    check("zs_a_greedy", a, 3);
    for (int i = 0; i < 100; i++) send_rand(16'hFFFF);
    idle(3);

    // load in the same cycle as a row: the row uses the old value
    send(4, 3, 2, 1, 16'hFFFF, 1'b1, 16'h1234);
    send(4, 3, 2, 1, 16'hFFFF, 1'b0, 16'h0);
    @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("ld_new_a", a, 0);
    check("ld_new_explore", explore, 1);

    for (int i = 0; i < 8; i++) send_rand(16'($urandom));
    idle(3);
    for (int i = 0; i < 4; i++) send_rand(16'($urandom));
    send(0, 0, 0, 0, 16'hFFFF, 1'b0, 16'h0);
    idle(3);
    check("eq_amax", amax, 0);
    check("eq_amin", amin, 0);

    send(1, 1, 1, 1, 16'h0, 1'b0, 16'h0);
    send(2, 2, 2, 2, 16'h0, 1'b0, 16'h0);
    q0 = 9; q1 = 9; q2 = 9; q3 = 9;
    in_valid = 1'b1;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mr_out_valid", out_valid, 0);
    check("mr_qmax", qmax, 0);
    in_valid = 1'b0;
    eq.delete();
    lfsr_m = 16'hACE1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    check("mr_no_emit", out_valid, 0);
    send(1, 2, 3, 4, 16'hFFFF, 1'b0, 16'h0);
    @(posedge clk); @(negedge clk);
    check("mr_lfsr_a", a, 1);
    check("mr_lfsr_explore", explore, 1);
    idle(3);
    check("drain", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
